// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate BIST controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Reference truth tables for 2-input gates; bit v is the output for vector v.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_bist_settle_cnt.sv
// Loadable down-counter that times how long each vector settles.
// Latency: zero flag reflects the registered count; load takes effect next cycle.
// Backpressure: none; load has priority over enable.
module gate_bist_settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic zero
);
    localparam int CW = $clog2(SETTLE) + 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(SETTLE - 1);
        end else if (enable && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gate_bist_ctrl.sv
// Sweeps every input vector into a combinational gate and checks it against a truth table.
// Latency: each vector takes SETTLE+1 cycles; done rises 2**N_IN*(SETTLE+1) cycles after start.
// Backpressure: start is ignored while a sweep is in progress.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2**N_IN-1:0]  expected_tt,
    output logic [N_IN-1:0]     dut_in,
    input  logic                dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_IN:0]       err_count,
    output logic [N_IN-1:0]     fail_vec
);
    localparam int              NV   = 2**N_IN;
    localparam logic [N_IN-1:0] LAST = '1;

    state_e          state;
    logic [NV-1:0]   tt_q;
    logic            accept;
    logic            mismatch;
    logic            is_last;
    logic            cnt_load;
    logic            cnt_en;
    logic            cnt_zero;
    logic [N_IN:0]   err_next;

    assign accept   = start && (state == ST_IDLE || state == ST_DONE);
    assign is_last  = (dut_in == LAST);
    // 4-state inequality so an X/Z from the gate is flagged in simulation.
    assign mismatch = (state == ST_CHECK) && (dut_out !== tt_q[dut_in]);
    assign err_next = err_count + (N_IN+1)'(mismatch);
    assign cnt_load = accept || (state == ST_CHECK && !is_last);
    assign cnt_en   = (state == ST_SETTLE) && !cnt_zero;

    gate_bist_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .enable (cnt_en),
        .zero   (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tt_q      <= '0;
            dut_in    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        tt_q      <= expected_tt;
                        err_count <= '0;
                        fail_vec  <= '0;
                        pass      <= 1'b0;
                        done      <= 1'b0;
                        dut_in    <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_count <= err_next;
                    if (mismatch && err_count == '0) begin
                        fail_vec <= dut_in;
                    end
                    if (is_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        state <= ST_DONE;
                    end else begin
                        dut_in <= dut_in + N_IN'(1);
                        state  <= ST_SETTLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Unused in this configuration; keeps the accept term visible for debug.
    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Self-checking bench for gate_bist_ctrl against a truth-table reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Instance A: SETTLE=1; instance B: SETTLE=3 driving a lagging gate.
    logic       start_a = 1'b0;
    logic [3:0] tt_a    = '0;
    logic [1:0] in_a;
    logic       out_a;
    logic       busy_a, done_a, pass_a;
    logic [2:0] err_a;
    logic [1:0] fail_a;

    logic       start_b = 1'b0;
    logic [3:0] tt_b    = '0;
    logic [1:0] in_b;
    logic       out_b;
    logic       busy_b, done_b, pass_b;
    logic [2:0] err_b;
    logic [1:0] fail_b;

    int         gate_mode = 0;
    logic [3:0] rand_tt   = '0;
    logic [1:0] lag_a1 = '0, lag_a2 = '0, lag_b1 = '0, lag_b2 = '0;

    int n_chk  = 0;
    int n_pass = 0;

    gate_bist_ctrl #(.N_IN(2), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected_tt(tt_a),
        .dut_in(in_a), .dut_out(out_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .fail_vec(fail_a)
    );

    gate_bist_ctrl #(.N_IN(2), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected_tt(tt_b),
        .dut_in(in_b), .dut_out(out_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .fail_vec(fail_b)
    );

    // and_gate_using_mux: y = a ? b : 0
    function automatic logic and_mux(input logic [1:0] v);
        return v[1] ? v[0] : 1'b0;
    endfunction

    always @(posedge clk) begin
        lag_a1 <= in_a;
        lag_a2 <= lag_a1;
        lag_b1 <= in_b;
        lag_b2 <= lag_b1;
    end

    always_comb begin
        case (gate_mode)
            0:       out_a = and_mux(in_a);
            1:       out_a = and_mux(lag_a2);
            default: out_a = rand_tt[in_a];
        endcase
    end
    assign out_b = and_mux(lag_b2);

    // Reference model: the sweep result is purely the difference of two truth tables.
    function automatic int ref_err(input logic [3:0] g, input logic [3:0] e);
        int n = 0;
        for (int v = 0; v < 4; v++) if (g[v] != e[v]) n++;
        return n;
    endfunction

    function automatic int ref_fail(input logic [3:0] g, input logic [3:0] e);
        for (int v = 0; v < 4; v++) if (g[v] != e[v]) return v;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sweep on instance A; lat = cycles from the accepting edge until done is seen.
    task automatic run_a(input bit track, input bit repulse, input bit scramble, output int lat);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        if (scramble) tt_a = 4'($urandom);
        chk("start_clears_done", done_a, 0);
        chk("start_sets_busy", busy_a, 1);
        lat = 0;
        while (!done_a && lat < 100) begin
            if (repulse && (lat == 2 || lat == 4)) start_a = 1'b1;
            tick();
            start_a = 1'b0;
            lat++;
            if (track) chk("vec_step", in_a, (lat / 2 > 3) ? 3 : lat / 2);
        end
    endtask

    task automatic chk_result_a(input string tag, input logic [3:0] g, input logic [3:0] e, input int lat);
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_err"}, err_a, ref_err(g, e));
        chk({tag, "_fail"}, fail_a, ref_fail(g, e));
        chk({tag, "_pass"}, pass_a, ref_err(g, e) == 0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_hold_in"}, in_a, 3);
    endtask

    initial begin
        int lat;
        logic [3:0] e;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in", in_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_fail", fail_a, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        gate_mode = 0;
        tt_a = TT_AND;
        run_a(1, 0, 0, lat);
        chk_result_a("and", TT_AND, TT_AND, lat);

        tt_a = TT_OR;
        run_a(0, 0, 0, lat);
        chk_result_a("or", TT_AND, TT_OR, lat);

        tt_a = TT_NAND;
        run_a(0, 0, 0, lat);
        chk_result_a("nand", TT_AND, TT_NAND, lat);

        tt_a = TT_AND;
        run_a(0, 1, 0, lat);
        chk_result_a("repulse", TT_AND, TT_AND, lat);
        run_a(0, 0, 0, lat);
        chk_result_a("restart", TT_AND, TT_AND, lat);

        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        lat = 0;
        while (in_a != 2 && lat < 50) begin
            tick();
            lat++;
        end
        chk("mid_reached_vec2", in_a, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in", in_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_err", err_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_a(0, 0, 0, lat);
        chk_result_a("post_rst", TT_AND, TT_AND, lat);

        tt_b = TT_AND;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 200) begin
            tick();
            lat++;
        end
        chk("lag_s3_lat", lat, 16);
        chk("lag_s3_pass", pass_b, 1);
        chk("lag_s3_err", err_b, 0);

        gate_mode = 1;
        tt_a = TT_AND;
        run_a(0, 0, 0, lat);
        chk("lag_s1_lat", lat, 8);
        chk("lag_s1_pass", pass_a, 0);
        chk("lag_s1_err_nz", err_a > 0, 1);

        gate_mode = 2;
        for (int i = 0; i < 30; i++) begin
            rand_tt = 4'($urandom);
            e = (i % 4 == 0) ? rand_tt : 4'($urandom);
            tt_a = e;
            run_a(0, 0, 1, lat);
            chk_result_a("rand", rand_tt, e, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1);
    end

endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
Built-in self-test controller for a small combinational gate such as a 2-input gate built from muxes. On a start pulse it sweeps every input vector into the gate under test. For each vector it waits a programmable settle time, then compares the gate output against a truth table supplied at start. It reports done, pass/fail, the mismatch count and the first failing vector, so gate-level homework blocks can be checked on the board without a simulator.

Parameters:
N_IN, 2, number of gate inputs; the controller sweeps 2**N_IN vectors.
SETTLE, 1, cycles each vector is held before sampling; legal range >= 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle start request; sampled only in IDLE or DONE
expected_tt  input  2**N_IN  truth table; bit v is the expected output for input vector v; latched at start
dut_in  output  N_IN  vector driven to the gate; dut_in[N_IN-1] is the MSB (for the AND gate, a = dut_in[1], b = dut_in[0])
dut_out  input  1  gate output, treated as combinational
busy  output  1  sweep in progress
done  output  1  sweep finished; held until the next accepted start
pass  output  1  valid when done; 1 means zero mismatches
err_count  output  N_IN+1  number of mismatching vectors
fail_vec  output  N_IN  first mismatching vector; 0 if none

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0; settle counter and latched truth table cleared.
  - Takes effect immediately, including mid-sweep; no partial result survives.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE or DONE with start=1 at edge k:
  - latch expected_tt.
  - clear err_count, fail_vec, pass and done.
  - dut_in=0, busy=1, load settle counter with SETTLE-1, go to SETTLE.
- SETTLE: counter decrements each cycle; when it reads 0, go to CHECK. dut_in is stable throughout.
- CHECK (one cycle):
  - mismatch when dut_out != expected_tt[dut_in]; in simulation an X/Z on dut_out also counts as a mismatch (4-state inequality).
  - on mismatch: err_count increments; fail_vec <= dut_in only if err_count was 0.
  - if dut_in == 2**N_IN-1: go to DONE, busy=0, done=1, pass = (final err_count == 0).
  - otherwise: dut_in increments, counter reloads SETTLE-1, go to SETTLE.
- Timing:
  - each vector occupies SETTLE+1 cycles.
  - done is first high after edge k + 2**N_IN*(SETTLE+1). For N_IN=2, SETTLE=1 that is 8 cycles.
- Error count range: err_count max is 2**N_IN, which fits in N_IN+1 bits, so no saturation is needed.
- start while busy (SETTLE or CHECK) is ignored, with no effect on the sweep.
- In DONE:
  - outputs hold their results.
  - dut_in holds the last vector (2**N_IN-1) until the next start.
  - a new start clears done on the next edge.
- expected_tt changes after start have no effect on the current sweep.

Decomposition:
- Package gate_bist_pkg:
  - state enum type.
  - truth-table constants for N_IN=2: TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111.
- One sub-module: gate_bist_settle_cnt.
  - loadable down-counter, width $clog2(SETTLE)+1.
  - ports: load, enable, zero flag.
- The top level holds the FSM, vector register and result registers.

Test Plan:
1. DUT = and_gate_using_mux, expected_tt=TT_AND, start pulse -> dut_in steps 00,01,10,11 every 2 cycles; done=1 at cycle 8; pass=1, err_count=0, fail_vec=00.
2. Same DUT, expected_tt=TT_OR -> mismatches at 01 and 10; err_count=2, fail_vec=2'b01, pass=0.
3. Same DUT, expected_tt=TT_NAND -> err_count=4, fail_vec=2'b00, pass=0.
4. start re-pulsed at cycles 3 and 5 during the sweep -> ignored, done still at cycle 8. Then start in DONE -> done=0 next cycle, full new sweep, done 8 cycles later.
5. rst_n pulled low while dut_in=10 -> all outputs 0 immediately, state IDLE. After release, start -> complete sweep with pass=1.
6. SETTLE=3 with a gate model whose output lags its inputs by 2 cycles, TT_AND -> pass=1, done at cycle 16. Same model with SETTLE=1 -> pass=0, err_count>0.
